// File: rtl/seq_multiplier.sv
// Iterative shift-and-add RV32M multiplier (MUL/MULH/MULHSU/MULHU), one product bit per cycle.
// The per-cycle add goes through a carry-lookahead adder tiled from 4-bit slices.

module seq_multiplier_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gg,
  output logic       pp
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded from cin directly, so no bit of c depends on another bit of c.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;
  assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pp  = &p;
endmodule

module seq_multiplier_cla_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned NG = WIDTH / 4;

  logic [NG-1:0] gg;
  logic [NG-1:0] pp;
  logic [NG-1:0] gc;

  for (genvar gi = 0; gi < NG; gi++) begin : g_slice
    seq_multiplier_cla4 u_cla4 (
      .a   (a[4*gi +: 4]),
      .b   (b[4*gi +: 4]),
      .cin (gc[gi]),
      .sum (sum[4*gi +: 4]),
      .gg  (gg[gi]),
      .pp  (pp[gi])
    );
  end

  // Group carries from slice generate/propagate; group terms never depend on their carry-in.
  always_comb begin
    logic carry;
    carry = cin;
    gc    = '0;
    for (int i = 0; i < NG; i++) begin
      gc[i] = carry;
      carry = gg[i] | (pp[i] & carry);
    end
    cout = carry;
  end
endmodule

module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       mul_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mag_a;
  logic [1:0]       op_q;
  logic             neg_q;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [ACC_W-1:0] acc_fix;
  logic             last_iter;

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);

  // Signedness and magnitudes of the incoming operands; -2^(W-1) keeps magnitude 2^(W-1).
  always_comb begin
    sign_a   = op_a[WIDTH-1] & ((mul_op == 2'b01) || (mul_op == 2'b10));
    sign_b   = op_b[WIDTH-1] & (mul_op == 2'b01);
    mag_a_in = sign_a ? (~op_a + WIDTH'(1)) : op_a;
    mag_b_in = sign_b ? (~op_b + WIDTH'(1)) : op_b;
  end

  assign addend = lo[0] ? mag_a : '0;

  seq_multiplier_cla_adder #(.WIDTH(WIDTH)) u_add (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Sign correction negates the full double-width product; carry past ACC_W bits drops.
  assign acc_fix   = neg_q ? (~{hi, lo} + ACC_W'(1)) : {hi, lo};
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: begin
        if (flush)          state_d = IDLE;
        else if (last_iter) state_d = FIX;
      end
      FIX:  state_d = flush ? IDLE : DONE;
      DONE: if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      mag_a  <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            count <= '0;
            hi    <= '0;
            lo    <= mag_b_in;
            mag_a <= mag_a_in;
            op_q  <= mul_op;
            neg_q <= sign_a ^ sign_b;
          end
        end
        BUSY: begin
          hi    <= {cout, sum[WIDTH-1:1]};
          lo    <= {sum[0], lo[WIDTH-1:1]};
          count <= count + CNT_W'(1);
        end
        FIX: begin
          {hi, lo} <= acc_fix;
          if (!flush) begin
            result <= (op_q == 2'b00) ? acc_fix[WIDTH-1:0] : acc_fix[ACC_W-1:WIDTH];
          end
        end
        DONE: begin
          if (flush || out_ready) result <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-and-add multiplier for the RV32M `MUL`/`MULH`/`MULHSU`/`MULHU` instructions. It sits directly downstream of the execute-stage operand mux and consumes one operand pair per request. It computes the 2·WIDTH-bit product one bit per cycle, using the team's carry-lookahead adder built from 4-bit CLA slices with GG/PP group lookahead. It returns the selected WIDTH-bit half through a valid/ready handshake to the writeback mux.

## Interface
- `WIDTH`, 32, operand width. Must be a multiple of 4 so the adder tiles into CLA slices.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: block can accept a request.
- `op_a` input WIDTH: multiplicand (rs1).
- `op_b` input WIDTH: multiplier (rs2).
- `mul_op` input 2: 00 MUL (low half), 01 MULH (signed×signed, high), 10 MULHSU (signed a × unsigned b, high), 11 MULHU (unsigned×unsigned, high).
- `flush` input 1: synchronous kill of the in-flight operation.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output WIDTH: selected product half.

## Operation
- **FSM states:** IDLE, BUSY, FIX, DONE.
  - `in_ready` = (state==IDLE) && `rst_n`.
  - `out_valid` = (state==DONE).
- **IDLE:** on `in_valid && in_ready`, latch the following and go to BUSY with `count`=0:
  - `mul_op`.
  - sign_a = `op_a[WIDTH-1]` if op ∈ {01,10}, else 0.
  - sign_b = `op_b[WIDTH-1]` if op==01, else 0.
  - mag_a = |op_a| and mag_b = |op_b| under those signs. Magnitudes are WIDTH-bit unsigned, so -2^(WIDTH-1) has magnitude 2^(WIDTH-1).
  - Clear the 2·WIDTH-bit accumulator {hi,lo}: lo=mag_b, hi=0.
- **BUSY:** each cycle:
  - sum = hi + (lo[0] ? mag_a : 0), computed as WIDTH+1 bits through the CLA adder.
  - {hi,lo} ← {sum, lo} >> 1.
  - `count`++.
  - After the iteration with `count`==WIDTH-1, go to FIX.
- **FIX:** if sign_a XOR sign_b, replace the accumulator with its two's complement (2·WIDTH bits). Then go to DONE.
- **DONE:** `result` = lo for op 00, hi otherwise. It is held stable until `out_valid && out_ready`, then the block returns to IDLE.
- **Input gating:** `in_valid` is ignored outside IDLE. Operands are not re-sampled after acceptance.
- **flush:** in BUSY, FIX or DONE, forces IDLE on the next edge. `out_valid` drops and no result is delivered. In IDLE it has no effect.
- **flush with accept:** if `flush` and an accepting `in_valid` coincide in IDLE, the request is accepted (flush applies only to in-flight work).
- **flush with completion:** `flush` and `out_ready` in the same DONE cycle result in IDLE; the consumer treats the result as discarded.
- **Reset:**
  - `rst_n` low at any edge → state IDLE, `count`=0, accumulator=0, `out_valid`=0, `result`=0.
  - `in_ready` is 0 while `rst_n` is low.
  - Reset mid-operation discards the work with no partial output.
- **Operand edge cases:**
  - Zero operand → product 0, no negation artefacts (the negation of 0 is 0).
  - Sign-correction carry-out beyond 2·WIDTH bits is discarded.

## Timing
- Accept at edge E0. Iterations at E1..E_WIDTH, sign fix at E_(WIDTH+1). `out_valid` is high after E_(WIDTH+1): WIDTH+1 cycles of latency (33 for WIDTH=32), independent of operand values.
- Result handshake completes at edge Ed. `in_ready` is high after Ed, so the earliest next accept is Ed+1. Throughput is one operation per WIDTH+3 cycles with zero backpressure.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid`/`out_ready`.
- The adder critical path is one WIDTH-bit CLA add plus a 2:1 mux per cycle.

## Test plan
- MUL 7 × 6 with `out_ready`=1 → `result`=0x0000002A, `out_valid` rises exactly 33 cycles after accept, `in_ready` high the cycle after completion.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MUL on the same operands → 0x00000000. MULH 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU on the same operands → 0xFFFFFFFE. MUL on the same operands → 0x00000001.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` and operands → `result` stable, `in_ready`=0, no new request accepted, single completion on release.
- Flush during BUSY at `count`=10 → `out_valid` never asserts, IDLE after the next edge. A following MULHU 0x12345678 × 0x9ABCDEF0 → 0x0B00EA4E.
- Reset: drive `rst_n`=0 during FIX → all outputs 0 and `in_ready`=0 during reset. After release, IDLE with `in_ready`=1 and a fresh MUL 3 × 0 → 0.
